// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NREQ message sources.
// Optional: define UART_TX_ARBITER_CRLF_EN to append 8'h0D 8'h0A after every message.
module uart_tx_arbiter #(
    parameter int NREQ   = 2,
    parameter int NBYTES = 4,
    parameter int CW     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*CW-1:0]       req_cnt,
    input  logic [NREQ*NBYTES*8-1:0] req_buf,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     tstart,
    output logic [7:0]               tbus,
    input  logic                     tready
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW = $clog2(NBYTES + 2);
    localparam int TW = $clog2(NBYTES + 3);
`ifdef UART_TX_ARBITER_CRLF_EN
    localparam int TAIL = 2;
`else
    localparam int TAIL = 0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_LO,
        WAIT_HI
    } state_t;

    state_t                state;
    logic [PW-1:0]         ptr;
    logic [PW-1:0]         win;
    logic [PW-1:0]         pick;
    logic [PW-1:0]         cand;
    logic                  pick_vld;
    logic [CW-1:0]         cnt_sel;
    logic [TW-1:0]         cnt_eff;
    logic [TW-1:0]         total;
    logic [TW-1:0]         n_total;
    logic [TW-1:0]         idx_inc;
    logic [IW-1:0]         idx;
    logic [NBYTES*8-1:0]   shreg;
    logic [7:0]            next_byte;

    // Descending offset scan so the smallest offset from ptr (highest priority) is assigned last.
    // NOTE: every always_comb output gets a default before any branch; otherwise a latch is inferred.
    always_comb begin
        pick     = ptr;
        pick_vld = 1'b0;
        cand     = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = PW'((int'(ptr) + off) % NREQ);
            if (req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_sel = req_cnt[int'(win)*CW +: CW];
        cnt_eff = (int'(cnt_sel) > NBYTES) ? TW'(NBYTES) : TW'(cnt_sel);
        total   = cnt_eff + TW'(TAIL);
        idx_inc = TW'(idx) + TW'(1);
    end

    always_comb begin
        next_byte = shreg[NBYTES*8-1 -: 8];
`ifdef UART_TX_ARBITER_CRLF_EN
        if (TW'(idx) == n_total - TW'(2))
            next_byte = 8'h0D;
        else if (TW'(idx) == n_total - TW'(1))
            next_byte = 8'h0A;
`endif
    end

    // NOTE: state is updated with non-blocking assignments only, so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= PW'(NREQ - 1);
            win     <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            tstart  <= 1'b0;
            tbus    <= 8'h00;
            shreg   <= '0;
            n_total <= '0;
            idx     <= '0;
        end else begin
            gnt    <= '0;
            tstart <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        win   <= pick;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // A source that dropped req before its grant has withdrawn.
                    if (!req[win]) begin
                        state <= IDLE;
                    end else begin
                        gnt     <= NREQ'(1) << win;
                        ptr     <= win;
                        shreg   <= req_buf[int'(win)*NBYTES*8 +: NBYTES*8];
                        n_total <= total;
                        idx     <= '0;
                        busy    <= (total != '0);
                        state   <= (total != '0) ? SEND : IDLE;
                    end
                end
                SEND: begin
                    if (tready) begin
                        tstart <= 1'b1;
                        tbus   <= next_byte;
                        shreg  <= shreg << 8;
                        state  <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!tready)
                        state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tready) begin
                        idx <= idx + IW'(1);
                        if (idx_inc == n_total) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx model driving tready.
module tb_uart_tx_arbiter;

    localparam int NREQ   = 2;
    localparam int NBYTES = 4;
    localparam int CW     = 3;
`ifdef UART_TX_ARBITER_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NREQ-1:0]          req;
    logic [NREQ*CW-1:0]       req_cnt;
    logic [NREQ*NBYTES*8-1:0] req_buf;
    logic [NREQ-1:0]          gnt;
    logic                     busy;
    logic                     tstart;
    logic [7:0]               tbus;
    logic                     tready;

    int vectors     = 0;
    int miscompares = 0;
    int uart_delay  = 3;
    int tstart_extra = 0;
    int tbus_moved   = 0;
    logic [7:0] sent[$];

    uart_tx_arbiter #(.NREQ(NREQ), .NBYTES(NBYTES), .CW(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_cnt (req_cnt),
        .req_buf (req_buf),
        .gnt     (gnt),
        .busy    (busy),
        .tstart  (tstart),
        .tbus    (tbus),
        .tready  (tready)
    );

    always #5 clk = ~clk;

    // uart_tx model: on tstart capture tbus, hold tready low for uart_delay cycles.
    initial begin
        logic [7:0] b;
        tready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tstart === 1'b1) begin
                b = tbus;
                sent.push_back(b);
                tready = 1'b0;
                for (int i = 0; i < uart_delay; i++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) break;
                    if (tstart !== 1'b0) tstart_extra++;
                    if (tbus !== b) tbus_moved++;
                end
                tready = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [47:0] sent_word();
        logic [47:0] w;
        w = '0;
        foreach (sent[i]) w = {w[39:0], sent[i]};
        return w;
    endfunction

    function automatic logic [47:0] exp_word(input logic [47:0] p);
        return CRLF ? {p[31:0], 16'h0D0A} : p;
    endfunction

    function automatic int exp_n(input int n);
        return n + (CRLF ? 2 : 0);
    endfunction

    task automatic apply_reset();
        rst_n   = 1'b0;
        req     = '0;
        req_cnt = '0;
        req_buf = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sent.delete();
        tstart_extra = 0;
        tbus_moved   = 0;
    endtask

    task automatic wait_gnt(input int budget, output logic [NREQ-1:0] g);
        g = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (gnt !== '0) begin
                g   = gnt;
                req = req & ~gnt;
                return;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && tready === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (tstart !== 1'b0) begin miscompares++; $display("FAIL reset_tstart: got %b expected 0", tstart); end
        vectors++; if (tbus !== 8'h00) begin miscompares++; $display("FAIL reset_tbus: got %h expected 00", tbus); end
    endtask

    task automatic test_single();
        bit ok;
        uart_delay = 3;
        sent.delete();
        req_cnt[2:0]  = 3'd2;
        req_buf[31:0] = 32'h4142_5555;
        req[0] = 1'b1;
        @(negedge clk);
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL single_gnt_early: got %b expected 00", gnt); end
        @(negedge clk);
        vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL single_gnt: got %b expected 01", gnt); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", busy); end
        req[0] = 1'b0;
        @(negedge clk);
        vectors++; if (tstart !== 1'b1) begin miscompares++; $display("FAIL single_tstart: got %b expected 1", tstart); end
        vectors++; if (tbus !== 8'h41) begin miscompares++; $display("FAIL single_tbus: got %h expected 41", tbus); end
        wait_done(200, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL single_done: busy still %b after budget", busy); end
        vectors++; if (sent.size() != exp_n(2)) begin miscompares++; $display("FAIL single_count: got %0d expected %0d", sent.size(), exp_n(2)); end
        vectors++; if (sent_word() !== exp_word(48'h4142)) begin miscompares++; $display("FAIL single_bytes: got %h expected %h", sent_word(), exp_word(48'h4142)); end
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] g;
        bit ok;
        apply_reset();
        uart_delay = 3;
        req_cnt = {3'd1, 3'd1};
        req_buf = {32'h2200_0000, 32'h1100_0000};
        for (int round = 0; round < 2; round++) begin
            sent.delete();
            req = 2'b11;
            wait_gnt(300, g);
            vectors++; if (g !== 2'b01) begin miscompares++; $display("FAIL contention_first r%0d: got %b expected 01", round, g); end
            wait_gnt(300, g);
            vectors++; if (g !== 2'b10) begin miscompares++; $display("FAIL contention_second r%0d: got %b expected 10", round, g); end
            wait_done(300, ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL contention_done r%0d: busy still %b", round, busy); end
            vectors++; if (sent.size() != (CRLF ? 6 : 2)) begin miscompares++; $display("FAIL contention_count r%0d: got %0d expected %0d", round, sent.size(), CRLF ? 6 : 2); end
            vectors++; if (sent_word() !== (CRLF ? 48'h110D0A_220D0A : 48'h1122)) begin miscompares++; $display("FAIL contention_bytes r%0d: got %h expected %h", round, sent_word(), CRLF ? 48'h110D0A_220D0A : 48'h1122); end
        end
    endtask

    task automatic test_cnt0();
        logic [NREQ-1:0] g;
        bit ok;
        uart_delay = 3;
        sent.delete();
        req_cnt[5:3] = 3'd0;
        req_buf[63:32] = 32'hDEAD_BEEF;
        req[1] = 1'b1;
        wait_gnt(50, g);
        vectors++; if (g !== 2'b10) begin miscompares++; $display("FAIL cnt0_gnt: got %b expected 10", g); end
        repeat (30) @(negedge clk);
        wait_done(100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL cnt0_done: busy still %b", busy); end
        vectors++; if (sent.size() != exp_n(0)) begin miscompares++; $display("FAIL cnt0_count: got %0d expected %0d", sent.size(), exp_n(0)); end
        vectors++; if (sent_word() !== exp_word(48'h0)) begin miscompares++; $display("FAIL cnt0_bytes: got %h expected %h", sent_word(), exp_word(48'h0)); end
    endtask

    task automatic test_buf_change();
        logic [NREQ-1:0] g;
        bit ok;
        uart_delay = 3;
        sent.delete();
        req_cnt[2:0]  = 3'd3;
        req_buf[31:0] = 32'hA1B2_C3D4;
        req[0] = 1'b1;
        wait_gnt(50, g);
        req_buf[31:0] = 32'hFFFF_FFFF;
        req_cnt[2:0]  = 3'd4;
        vectors++; if (g !== 2'b01) begin miscompares++; $display("FAIL bufchg_gnt: got %b expected 01", g); end
        wait_done(300, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL bufchg_done: busy still %b", busy); end
        vectors++; if (sent.size() != exp_n(3)) begin miscompares++; $display("FAIL bufchg_count: got %0d expected %0d", sent.size(), exp_n(3)); end
        vectors++; if (sent_word() !== exp_word(48'hA1B2C3)) begin miscompares++; $display("FAIL bufchg_bytes: got %h expected %h", sent_word(), exp_word(48'hA1B2C3)); end
    endtask

    task automatic test_clamp();
        logic [NREQ-1:0] g;
        bit ok;
        uart_delay = 2;
        sent.delete();
        req_cnt[2:0]  = 3'd7;
        req_buf[31:0] = 32'h1020_3040;
        req[0] = 1'b1;
        wait_gnt(50, g);
        vectors++; if (g !== 2'b01) begin miscompares++; $display("FAIL clamp_gnt: got %b expected 01", g); end
        wait_done(300, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL clamp_done: busy still %b", busy); end
        vectors++; if (sent.size() != exp_n(4)) begin miscompares++; $display("FAIL clamp_count: got %0d expected %0d", sent.size(), exp_n(4)); end
        vectors++; if (sent_word() !== exp_word(48'h10203040)) begin miscompares++; $display("FAIL clamp_bytes: got %h expected %h", sent_word(), exp_word(48'h10203040)); end
    endtask

    task automatic test_slow_uart();
        logic [NREQ-1:0] g;
        bit ok;
        uart_delay   = 100;
        tstart_extra = 0;
        tbus_moved   = 0;
        sent.delete();
        req_cnt[5:3]   = 3'd4;
        req_buf[63:32] = 32'h5AA5_3CC3;
        req[1] = 1'b1;
        wait_gnt(50, g);
        vectors++; if (g !== 2'b10) begin miscompares++; $display("FAIL slow_gnt: got %b expected 10", g); end
        wait_done(2000, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL slow_done: busy still %b", busy); end
        vectors++; if (sent.size() != exp_n(4)) begin miscompares++; $display("FAIL slow_count: got %0d expected %0d", sent.size(), exp_n(4)); end
        vectors++; if (sent_word() !== exp_word(48'h5AA53CC3)) begin miscompares++; $display("FAIL slow_bytes: got %h expected %h", sent_word(), exp_word(48'h5AA53CC3)); end
        vectors++; if (tstart_extra != 0) begin miscompares++; $display("FAIL slow_tstart_width: got %0d extra high cycles expected 0", tstart_extra); end
        vectors++; if (tbus_moved != 0) begin miscompares++; $display("FAIL slow_tbus_stable: got %0d changes expected 0", tbus_moved); end
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] g;
        bit ok;
        bit low_seen;
        uart_delay = 20;
        sent.delete();
        req_cnt[2:0]  = 3'd3;
        req_buf[31:0] = 32'hC0C1_C2C3;
        req[0] = 1'b1;
        wait_gnt(50, g);
        low_seen = 1'b0;
        for (int i = 0; i < 20 && !low_seen; i++) begin
            @(negedge clk);
            if (tready === 1'b0) low_seen = 1'b1;
        end
        vectors++; if (!low_seen) begin miscompares++; $display("FAIL rstmid_tready_low: tready stayed %b", tready); end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++; if (tstart !== 1'b0) begin miscompares++; $display("FAIL rstmid_tstart: got %b expected 0", tstart); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL rstmid_gnt: got %b expected 00", gnt); end
        vectors++; if (tbus !== 8'h00) begin miscompares++; $display("FAIL rstmid_tbus: got %h expected 00", tbus); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sent.delete();
        uart_delay = 3;
        req_cnt = {3'd1, 3'd1};
        req_buf = {32'h8800_0000, 32'h7700_0000};
        req = 2'b11;
        wait_gnt(50, g);
        vectors++; if (g !== 2'b01) begin miscompares++; $display("FAIL rstmid_first: got %b expected 01", g); end
        wait_gnt(300, g);
        vectors++; if (g !== 2'b10) begin miscompares++; $display("FAIL rstmid_second: got %b expected 10", g); end
        wait_done(300, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_done: busy still %b", busy); end
        vectors++; if (sent.size() != (CRLF ? 6 : 2)) begin miscompares++; $display("FAIL rstmid_count: got %0d expected %0d", sent.size(), CRLF ? 6 : 2); end
        vectors++; if (sent_word() !== (CRLF ? 48'h770D0A_880D0A : 48'h7788)) begin miscompares++; $display("FAIL rstmid_bytes: got %h expected %h", sent_word(), CRLF ? 48'h770D0A_880D0A : 48'h7788); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_cnt0();
        test_buf_change();
        test_clamp();
        test_slow_uart();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
